// File: rtl/training_pkg.sv
// Shared types and default widths for the interval training timer.
package training_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    REST = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned SEC_W_DEF = 8;
  localparam int unsigned RND_W_DEF = 4;

endpackage

// File: rtl/training_timer_edge_sync.sv
// N-flop synchronizer for a slow divided clock treated as data, with a
// registered one-cycle pulse on each synchronized rising edge.
module edge_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], din};
      prev_q <= sync_q[N-1];
      rise   <= sync_q[N-1] & ~prev_q;
    end
  end

  assign level = sync_q[N-1];

endmodule

// File: rtl/training_timer.sv
// Interval training timer: WORK/REST rounds counted down on 1 Hz ticks.
// Optional buzzer tone enabled by defining TRAINING_BUZZER_EN.
module training_timer
  import training_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SEC_W       = SEC_W_DEF,
  parameter int unsigned RND_W       = RND_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_1hz,
  input  logic             clk_2khz,
  input  logic             start,
  input  logic             pause,
  input  logic             abort,
  input  logic [SEC_W-1:0] work_sec,
  input  logic [SEC_W-1:0] rest_sec,
  input  logic [RND_W-1:0] rounds,
  output logic [1:0]       state,
  output logic [SEC_W-1:0] sec_left,
  output logic [RND_W-1:0] round_cnt,
  output logic             busy,
  output logic             phase_done,
  output logic             buzzer
);

  state_t           st, st_n;
  logic [SEC_W-1:0] sec_n, lat_work, lat_rest;
  logic [RND_W-1:0] rnd_n, lat_rounds;
  logic             pd_n, buzz_win, win_n, load, tick, adv;
  logic             unused_level_1hz;

  edge_sync #(.N(SYNC_STAGES)) u_sync_1hz (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_1hz),
    .level (unused_level_1hz),
    .rise  (tick)
  );

  assign adv = tick & ~pause;

  always_comb begin
    st_n  = st;
    sec_n = sec_left;
    rnd_n = round_cnt;
    pd_n  = 1'b0;
    win_n = buzz_win;
    load  = 1'b0;
    if (abort) begin
      st_n  = IDLE;
      sec_n = '0;
      rnd_n = '0;
      win_n = 1'b0;
    end else begin
      if (adv) win_n = 1'b0;
      case (st)
        IDLE: begin
          if (start && rounds != '0 && work_sec != '0) begin
            load  = 1'b1;
            st_n  = WORK;
            sec_n = work_sec;
            rnd_n = RND_W'(1);
          end
        end
        WORK, REST: begin
          if (adv) begin
            if (sec_left > SEC_W'(1)) begin
              sec_n = sec_left - SEC_W'(1);
            end else begin
              pd_n  = 1'b1;
              win_n = 1'b1;
              if (st == REST || (round_cnt != lat_rounds && lat_rest == '0)) begin
                st_n  = WORK;
                sec_n = lat_work;
                rnd_n = round_cnt + RND_W'(1);
              end else if (round_cnt == lat_rounds) begin
                st_n  = DONE;
                sec_n = '0;
              end else begin
                st_n  = REST;
                sec_n = lat_rest;
              end
            end
          end
        end
        DONE: begin
          if (adv) begin
            st_n  = IDLE;
            sec_n = '0;
            rnd_n = '0;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      sec_left   <= '0;
      round_cnt  <= '0;
      phase_done <= 1'b0;
      buzz_win   <= 1'b0;
      lat_work   <= '0;
      lat_rest   <= '0;
      lat_rounds <= '0;
    end else begin
      st         <= st_n;
      sec_left   <= sec_n;
      round_cnt  <= rnd_n;
      phase_done <= pd_n;
      buzz_win   <= win_n;
      if (load) begin
        lat_work   <= work_sec;
        lat_rest   <= rest_sec;
        lat_rounds <= rounds;
      end
    end
  end

  assign state = st;
  assign busy  = (st != IDLE);

`ifdef TRAINING_BUZZER_EN
  logic tone, unused_rise_2khz;

  edge_sync #(.N(SYNC_STAGES)) u_sync_2khz (
    .clk   (clk),
    .rst   (rst),
    .din   (clk_2khz),
    .level (tone),
    .rise  (unused_rise_2khz)
  );

  assign buzzer = (buzz_win | (st == DONE)) & tone;
`else
  logic unused_2khz;
  assign unused_2khz = clk_2khz ^ buzz_win;
  assign buzzer      = 1'b0;
`endif

endmodule

// File: tb/tb_training_timer.sv
// Scoreboard bench for training_timer: a session schedule model predicts
// each observable state change; a monitor compares on every change.
module tb_training_timer;
  import training_pkg::*;

  localparam int unsigned NS = 2;
  localparam int unsigned SW = 8;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_1hz = 1'b0, clk_2khz = 1'b0;
  logic          start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [SW-1:0] work_sec = '0, rest_sec = '0, sec_left;
  logic [RW-1:0] rounds = '0, round_cnt;
  logic [1:0]    state;
  logic          busy, phase_done, buzzer;

  training_timer #(.SYNC_STAGES(NS), .SEC_W(SW), .RND_W(RW)) dut (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .clk_2khz(clk_2khz),
    .start(start), .pause(pause), .abort(abort),
    .work_sec(work_sec), .rest_sec(rest_sec), .rounds(rounds),
    .state(state), .sec_left(sec_left), .round_cnt(round_cnt),
    .busy(busy), .phase_done(phase_done), .buzzer(buzzer)
  );

  always #10 clk = ~clk;

  initial forever begin
    repeat (3) @(posedge clk);
    #1 clk_2khz = ~clk_2khz;
  end

  typedef struct packed {
    logic [1:0]    st;
    logic [SW-1:0] sec;
    logic [RW-1:0] rnd;
    logic          pd;
  } ev_t;

  ev_t expq[$];
  ev_t sched[$];
  int  checks = 0, errors = 0, pd_seen = 0;
  logic [3:0] hist = '0;

  always @(posedge clk) hist <= {hist[2:0], clk_2khz};

  function automatic ev_t mk(logic [1:0] st, int unsigned sec, int unsigned rnd, logic pd);
    ev_t e;
    e.st = st; e.sec = SW'(sec); e.rnd = RW'(rnd); e.pd = pd;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Whole session laid out up front; each accepted tick steps to the next entry.
  task automatic model_start(input int unsigned w, input int unsigned rs, input int unsigned n);
    if (sched.size() != 0 || n == 0 || w == 0) return;
    for (int unsigned r = 1; r <= n; r++) begin
      for (int unsigned s = w; s >= 1; s--) sched.push_back(mk(WORK, s, r, s == w && r > 1));
      if (r < n)
        for (int unsigned s = rs; s >= 1; s--) sched.push_back(mk(REST, s, r, s == rs));
    end
    sched.push_back(mk(DONE, 0, n, 1'b1));
    sched.push_back(mk(IDLE, 0, 0, 1'b0));
    expq.push_back(sched.pop_front());
  endtask

  task automatic model_abort();
    if (sched.size() != 0) begin
      sched.delete();
      expq.push_back(mk(IDLE, 0, 0, 1'b0));
    end
  endtask

  always @(negedge clk) begin : monitor
    static ev_t prev = '0;
    ev_t cur, e;
    logic exp_buz;
    cur = {state, sec_left, round_cnt, phase_done};
    if (!rst) begin
      if (phase_done) pd_seen++;
      if (cur[SW+RW+2:1] !== prev[SW+RW+2:1]) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got st=%0d sec=%0d rnd=%0d pd=%0b, required no change",
                   cur.st, cur.sec, cur.rnd, cur.pd);
        end else begin
          e = expq.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL event: got st=%0d sec=%0d rnd=%0d pd=%0b, required st=%0d sec=%0d rnd=%0d pd=%0b",
                     cur.st, cur.sec, cur.rnd, cur.pd, e.st, e.sec, e.rnd, e.pd);
          end
          check("busy", {31'd0, busy}, {31'd0, e.st != IDLE});
`ifdef TRAINING_BUZZER_EN
          exp_buz = (e.pd || e.st == DONE) ? hist[NS-1] : 1'b0;
          check("buzzer_evt", {31'd0, buzzer}, {31'd0, exp_buz});
`endif
        end
      end else if (phase_done) begin
        checks++;
        errors++;
        $display("FAIL spurious_phase_done: got 1 required 0 (st=%0d sec=%0d)", state, sec_left);
      end
`ifndef TRAINING_BUZZER_EN
      exp_buz = 1'b0;
      check("buzzer_off", {31'd0, buzzer}, {31'd0, exp_buz});
`endif
    end
    prev = cur;
  end

  // All drive tasks enter and leave 1 time unit after a rising clk edge.
  task automatic do_tick(input bit paused);
    pause = paused;
    if (!paused && sched.size() != 0) expq.push_back(sched.pop_front());
    clk_1hz = 1'b1;
    repeat (NS + 3) @(posedge clk);
    #1 clk_1hz = 1'b0;
    repeat (NS + 2) @(posedge clk);
    #1 pause = 1'b0;
  endtask

  task automatic do_start(input int unsigned w, input int unsigned rs, input int unsigned n);
    work_sec = SW'(w); rest_sec = SW'(rs); rounds = RW'(n);
    model_start(w, rs, n);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    work_sec = SW'($urandom); rest_sec = SW'($urandom); rounds = RW'($urandom);
  endtask

  task automatic do_abort();
    model_abort();
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  task automatic abort_on_tick();
    model_abort();
    clk_1hz = 1'b1;
    repeat (NS + 1) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    clk_1hz = 1'b0;
    repeat (NS + 3) @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 200 && sched.size() != 0; i++) do_tick(1'b0);
    check("run_to_idle", sched.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_sec"}, sec_left, 0);
    check({tag, "_rnd"}, round_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pd"}, phase_done, 0);
    check({tag, "_buzzer"}, buzzer, 0);
  endtask

  initial begin
    int pd0;
    int unsigned r;
    #2 rst = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // work 3 / rest 2 / 2 rounds
    pd0 = pd_seen;
    do_start(3, 2, 2);
    run_to_idle();
    check("pd_count_3_2_2", pd_seen - pd0, 3);

    // no rest: WORK->WORK, DONE after six ticks
    do_start(2, 0, 3);
    for (int i = 0; i < 6; i++) do_tick(1'b0);
    check("norest_done", state, DONE);
    check("norest_rounds", round_cnt, 3);
    do_tick(1'b0);

    // pause across two ticks at sec_left=5
    do_start(9, 1, 1);
    for (int i = 0; i < 4; i++) do_tick(1'b0);
    do_tick(1'b1);
    do_tick(1'b1);
    check("pause_hold", sec_left, 5);
    do_tick(1'b0);
    check("pause_release", sec_left, 4);
    do_abort();

    // abort coincident with the final tick of a phase
    pd0 = pd_seen;
    do_start(2, 1, 1);
    do_tick(1'b0);
    abort_on_tick();
    check("abort_tick_state", state, IDLE);
    check("abort_tick_sec", sec_left, 0);
    check("abort_tick_pd", pd_seen - pd0, 0);

    // illegal start, then restart attempt mid-session
    do_start(3, 1, 0);
    check("start_rounds0_busy", busy, 0);
    do_start(0, 1, 2);
    check("start_work0_busy", busy, 0);
    do_start(4, 1, 2);
    do_tick(1'b0);
    do_start(7, 7, 3);
    run_to_idle();

    // reset mid-phase abandons the session
    do_start(5, 2, 2);
    do_tick(1'b0);
    #2 rst = 1'b1;
    expq.delete();
    sched.delete();
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // randomized sessions with pauses, restarts and aborts mixed in
    for (int s = 0; s < 12; s++) begin
      do_start($urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < 60 && sched.size() != 0; i++) begin
        r = $urandom_range(0, 19);
        if (r < 3) do_tick(1'b1);
        else if (r == 3) do_start($urandom_range(1, 9), $urandom_range(0, 9), $urandom_range(1, 9));
        else if (r == 4 && $urandom_range(0, 3) == 0) do_abort();
        else do_tick(1'b0);
      end
      if (sched.size() != 0) do_abort();
      repeat (2) @(posedge clk);
      #1;
    end

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    #1 check("drain", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
